// File: rtl/wb_master_bridge_if.sv
// Command/response channels and Wishbone B4 classic initiator bus.
// master: the bridge side; slave: the command source and bus target side.
interface wb_master_bridge_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i,
    input  cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o,
    output rsp_err_o, wbm_cyc_o, wbm_stb_o,
    output wbm_we_o, wbm_sel_o, wbm_adr_o,
    output wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i,
    output cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o,
    input  rsp_err_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_we_o, wbm_sel_o, wbm_adr_o,
    input  wbm_dat_o
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic initiator: one command in, one bus cycle, one response out.
// Define WB_MASTER_TIMEOUT_EN to build the stb timeout counter and error path.
module wb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  wb_master_bridge_if.master wb
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_d;
  logic        accept;
  logic        ack_hit;
  logic        tmo_hit;
  logic        tmo_fire;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        err;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  // State register; reset returns to IDLE and drops any pending response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_d;
  end

  // Next state and one-cycle strobes; ack beats a timeout on the same edge.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    ack_hit  = 1'b0;
    tmo_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb.cmd_valid_i) begin
          accept  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb.wbm_ack_i) begin
          ack_hit = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (wb.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus output registers and captured read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc  <= 1'b0;
      stb  <= 1'b0;
      we   <= 1'b0;
      adr  <= '0;
      dat  <= '0;
      sel  <= '0;
      rdat <= '0;
    end else begin
      if (accept) begin
        cyc <= 1'b1;
        stb <= 1'b1;
        we  <= wb.cmd_we_i;
        adr <= wb.cmd_adr_i;
        dat <= wb.cmd_dat_i;
        sel <= wb.cmd_sel_i;
      end
      if (ack_hit || tmo_fire) begin
        cyc  <= 1'b0;
        stb  <= 1'b0;
        we   <= 1'b0;
        rdat <= (ack_hit && !we) ? wb.wbm_dat_i : '0;
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tmo_hit = (cnt == TMAX);

  // Counts stb cycles without ack; stops at TMAX so it never wraps.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      cnt <= '0;
    else if (accept)
      cnt <= '0;
    else if (state == BUS && !wb.wbm_ack_i && !tmo_hit)
      cnt <= cnt + 1'b1;
  end

  // Error flag for the response being produced.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                 err <= 1'b0;
    else if (ack_hit || tmo_fire) err <= tmo_fire;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign wb.cmd_ready_o = (state == IDLE) && !wb_rst_i;
  assign wb.rsp_valid_o = (state == RESP);
  assign wb.rsp_dat_o   = rdat;
  assign wb.rsp_err_o   = err;
  assign wb.wbm_cyc_o   = cyc;
  assign wb.wbm_stb_o   = stb;
  assign wb.wbm_we_o    = we;
  assign wb.wbm_sel_o   = sel;
  assign wb.wbm_adr_o   = adr;
  assign wb.wbm_dat_o   = dat;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: directed cases then random transactions
// scored against a per-transaction latency/response model.
module tb_wb_master_bridge;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 0;
`endif
  localparam int TPARAM = (TMO > 0) ? TMO : 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_adr = '0;

  wb_master_bridge_if b();

  wb_master_bridge #(.TIMEOUT_CYCLES(TPARAM)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb(b.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) begin
      b.cmd_valid_i = 1'b0;
      b.wbm_ack_i = 1'($urandom_range(0, 1));
      b.wbm_dat_i = $urandom;
      @(negedge clk);
      check("idle_rdy", 32'(b.cmd_ready_o), 32'd1);
      check("idle_ctl",
            32'({b.wbm_cyc_o, b.wbm_stb_o, b.rsp_valid_o}), 32'd0);
      check("idle_adr", b.wbm_adr_o, last_adr);
    end
    b.wbm_ack_i = 1'b0;
  endtask

  // Starts at a negedge with the bridge idle; returns at the negedge
  // after the response handshake with the bridge idle again.
  task automatic txn(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input int waits, input logic [31:0] rd,
                     input int bp, input logic hold);
    int n;
    int exp_n;
    logic exp_err;
    logic [31:0] exp_dat;
    b.cmd_valid_i = 1'b1;
    b.cmd_we_i = we;
    b.cmd_adr_i = adr;
    b.cmd_dat_i = dat;
    b.cmd_sel_i = sel;
    check("cmd_rdy", 32'(b.cmd_ready_o), 32'd1);
    @(negedge clk);
    b.cmd_valid_i = 1'b0;
    b.cmd_we_i = 1'($urandom);
    b.cmd_adr_i = $urandom;
    b.cmd_dat_i = $urandom;
    b.cmd_sel_i = 4'($urandom);
    last_adr = adr;
    n = 0;
    while (n < 64 && b.wbm_stb_o) begin
      n++;
      check("bus_ctl",
            32'({b.wbm_cyc_o, b.wbm_we_o, b.wbm_sel_o,
                 b.cmd_ready_o, b.rsp_valid_o}),
            32'({1'b1, we, sel, 2'b00}));
      check("bus_adr", b.wbm_adr_o, adr);
      check("bus_dat", b.wbm_dat_o, dat);
      b.wbm_ack_i = (n == waits + 1);
      b.wbm_dat_i = (n == waits + 1) ? rd : $urandom;
      @(negedge clk);
    end
    b.wbm_ack_i = 1'b0;
    exp_err = (TMO > 0) && (waits + 1 > TMO);
    exp_n = exp_err ? TMO : waits + 1;
    exp_dat = (we || exp_err) ? 32'd0 : rd;
    check("stb_cycles", n, exp_n);
    for (int i = 0; i <= bp; i++) begin
      check("rsp_valid", 32'(b.rsp_valid_o), 32'd1);
      check("rsp_dat", b.rsp_dat_o, exp_dat);
      check("rsp_err", 32'(b.rsp_err_o), 32'(exp_err));
      check("rsp_ctl",
            32'({b.wbm_cyc_o, b.wbm_stb_o, b.wbm_we_o,
                 b.cmd_ready_o}), 32'd0);
      b.rsp_ready_i = (i == bp);
      b.wbm_ack_i = 1'($urandom_range(0, 1));
      b.wbm_dat_i = $urandom;
      b.cmd_valid_i = hold;
      b.cmd_we_i = 1'($urandom);
      b.cmd_adr_i = $urandom;
      @(negedge clk);
    end
    check("rsp_done", 32'({b.rsp_valid_o, b.cmd_ready_o}), 32'b01);
    b.rsp_ready_i = 1'b0;
    b.cmd_valid_i = 1'b0;
    b.wbm_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b.cmd_valid_i = 1'b0;
    b.cmd_we_i = 1'b0;
    b.cmd_adr_i = '0;
    b.cmd_dat_i = '0;
    b.cmd_sel_i = '0;
    b.rsp_ready_i = 1'b0;
    b.wbm_ack_i = 1'b0;
    b.wbm_dat_i = '0;

    @(negedge clk);
    check("rst_ctl",
          32'({b.cmd_ready_o, b.rsp_valid_o, b.rsp_err_o,
               b.wbm_cyc_o, b.wbm_stb_o, b.wbm_we_o,
               b.wbm_sel_o}), 32'd0);
    check("rst_adr", b.wbm_adr_o, 32'd0);
    check("rst_wdat", b.wbm_dat_o, 32'd0);
    check("rst_rdat", b.rsp_dat_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_rdy", 32'(b.cmd_ready_o), 32'd1);

    txn(1'b0, 32'h3000_0004, $urandom, 4'hF, 0,
        32'hA5A5_1234, 0, 1'b0);
    txn(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hC, 3,
        $urandom, 0, 1'b0);
    txn(1'b0, 32'h3000_0020, $urandom, 4'hF, 1,
        32'h1234_5678, 5, 1'b1);
    idle_gap(3);

`ifdef WB_MASTER_TIMEOUT_EN
    txn(1'b0, 32'h3000_0030, $urandom, 4'hF, 1000,
        32'h5555_AAAA, 0, 1'b0);
    txn(1'b0, 32'h3000_0034, $urandom, 4'hF, TMO - 1,
        32'hCAFE_F00D, 0, 1'b0);
`else
    txn(1'b0, 32'h3000_0030, $urandom, 4'hF, 40,
        32'hCAFE_F00D, 0, 1'b0);
`endif

    b.cmd_valid_i = 1'b1;
    b.cmd_we_i = 1'b1;
    b.cmd_adr_i = 32'h3000_0040;
    b.cmd_dat_i = 32'h0BAD_0BAD;
    b.cmd_sel_i = 4'hF;
    @(negedge clk);
    b.cmd_valid_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mrst_bus",
             32'({b.wbm_cyc_o, b.wbm_stb_o, b.cmd_ready_o}), 32'd0);
    @(negedge clk);
    check("mrst_rsp", 32'(b.rsp_valid_o), 32'd0);
    rst = 1'b0;
    last_adr = '0;
    idle_gap(3);
    txn(1'b0, 32'h3000_0044, $urandom, 4'h3, 2,
        32'h0F0F_F0F0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      txn(1'($urandom), $urandom, $urandom, 4'($urandom),
          $urandom_range(0, 5), $urandom,
          $urandom_range(0, 3), 1'($urandom));
      idle_gap($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
